// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the parametrised convolutional encoder.
package conv_enc_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_TAIL = 1'b1
  } enc_state_t;

  localparam int TERM_STREAM = 0;
  localparam int TERM_ZERO   = 1;

  localparam logic [5:0]  G_K3_75      = {3'b111, 3'b101};
  localparam logic [13:0] G_K7_171_133 = {7'b1111001, 7'b1011011};

endpackage

// File: rtl/conv_enc_parity.sv
// One generator output: XOR-reduction of a K-bit generator slice against its tap vector.
module conv_enc_parity #(
  parameter int K = 3
) (
  input  logic [K-1:0] gen,
  input  logic [K-1:0] taps,
  output logic         parity
);

  assign parity = ^(gen & taps);

endmodule

// File: rtl/conv_encoder_param.sv
// Rate 1/N, constraint-length K feed-forward convolutional encoder with registered valid/ready output.
// Optional puncturing (out_mask port, dropped all-zero-mask symbols) is enabled by CONV_ENC_PUNCT_EN.
module conv_encoder_param
  import conv_enc_pkg::*;
#(
  parameter int             K         = 3,
  parameter int             N         = 2,
  parameter logic [N*K-1:0] G         = G_K3_75,
  parameter int             TERM_MODE = TERM_ZERO
`ifdef CONV_ENC_PUNCT_EN
  ,
  parameter int                   PUNCT_P   = 2,
  parameter logic [N*PUNCT_P-1:0] PUNCT_PAT = 4'b1110
`endif
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sym,
  output logic         out_last,
`ifdef CONV_ENC_PUNCT_EN
  output logic [N-1:0] out_mask,
`endif
  output logic         busy
);

  enc_state_t   state;
  logic [K-2:0] sreg;
  logic [K-2:0] shifted;
  logic [K-1:0] taps;
  logic [N-1:0] sym;
  logic [3:0]   tail_cnt;
  logic         cur_bit;
  logic         slot_free;
  logic         accept;
  logic         tail_step;
  logic         step;
  logic         tail_done;
  logic         last_sym;
  logic         emit_valid;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == S_DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign tail_step = (state == S_TAIL) && slot_free;
  assign step      = accept || tail_step;
  assign cur_bit   = (state == S_DATA) ? in_bit : 1'b0;
  assign tail_done = tail_step && (tail_cnt == 4'(K - 2));
  assign last_sym  = tail_done || (accept && in_last && (TERM_MODE == TERM_STREAM));
  assign busy      = (state == S_TAIL) || out_valid;

  // Tap vector: current bit at K-1, newest register bit below it, oldest at bit 0.
  always_comb begin
    taps[K-1] = cur_bit;
    for (int i = 0; i < K - 1; i++) begin
      taps[K-2-i] = sreg[i];
    end
  end

  if (K > 2) begin : g_shift
    assign shifted = {sreg[K-3:0], cur_bit};
  end else begin : g_shift1
    assign shifted = cur_bit;
  end

  for (genvar j = 0; j < N; j++) begin : g_parity
    conv_enc_parity #(.K(K)) u_parity (
      .gen    (G[j*K +: K]),
      .taps   (taps),
      .parity (sym[j])
    );
  end

`ifdef CONV_ENC_PUNCT_EN
  logic [7:0]   phase;
  logic [N-1:0] mask;

  assign mask = PUNCT_PAT[(PUNCT_P - 1 - int'(phase)) * N +: N];
  // The frame-final symbol is always emitted so downstream never loses the boundary.
  assign emit_valid = (|mask) || last_sym;

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase    <= '0;
      out_mask <= '0;
    end else if (step) begin
      out_mask <= mask;
      if (last_sym || (int'(phase) == PUNCT_P - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end
`else
  assign emit_valid = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_DATA;
      sreg      <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_last  <= 1'b0;
    end else if (step) begin
      out_sym   <= sym;
      out_last  <= last_sym;
      out_valid <= emit_valid;
      sreg      <= last_sym ? '0 : shifted;
      if (accept && in_last && (TERM_MODE == TERM_ZERO)) begin
        state    <= S_TAIL;
        tail_cnt <= '0;
      end else if (tail_step) begin
        if (tail_done) begin
          state    <= S_DATA;
          tail_cnt <= '0;
        end else begin
          tail_cnt <= tail_cnt + 4'd1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed self-checking bench: a zero-tail instance (a) and a stream instance (b) share stimulus.
module tb_conv_encoder_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_bit;
  logic       in_last;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [1:0] a_out_sym;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [1:0] b_out_sym;
`ifdef CONV_ENC_PUNCT_EN
  logic [1:0] a_out_mask, b_out_mask;
`endif

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic       bits1 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] exp1  [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [1:0] mask1 [6] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};

  always #5 CLK = ~CLK;

  conv_encoder_param #(.K(3), .N(2), .G(6'b111101), .TERM_MODE(1)) dut_a (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_sym   (a_out_sym),
    .out_last  (a_out_last),
`ifdef CONV_ENC_PUNCT_EN
    .out_mask  (a_out_mask),
`endif
    .busy      (a_busy)
  );

  conv_encoder_param #(.K(3), .N(2), .G(6'b111101), .TERM_MODE(0)) dut_b (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_sym   (b_out_sym),
    .out_last  (b_out_last),
`ifdef CONV_ENC_PUNCT_EN
    .out_mask  (b_out_mask),
`endif
    .busy      (b_busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic l, input logic r);
    in_valid  = v;
    in_bit    = b;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkSymA(input string tag, input logic [1:0] es, input logic el);
    checkOutput({tag, " a valid"}, 32'(a_out_valid), 32'd1);
    checkOutput({tag, " a sym"},   32'(a_out_sym),   32'(es));
    checkOutput({tag, " a last"},  32'(a_out_last),  32'(el));
  endtask

  task automatic checkSymB(input string tag, input logic [1:0] es, input logic el);
    checkOutput({tag, " b valid"}, 32'(b_out_valid), 32'd1);
    checkOutput({tag, " b sym"},   32'(b_out_sym),   32'(es));
    checkOutput({tag, " b last"},  32'(b_out_last),  32'(el));
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    RST = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst valid",    32'(a_out_valid), 32'd0);
    checkOutput("rst sym",      32'(a_out_sym),   32'd0);
    checkOutput("rst last",     32'(a_out_last),  32'd0);
    checkOutput("rst busy",     32'(a_busy),      32'd0);
    checkOutput("rst in_ready", 32'(a_in_ready),  32'd1);

    // Zero-tail frame 1,0,1,1 at full throughput
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, bits1[i], (i == 3), 1'b1);
      tick();
      checkSymA($sformatf("t1 sym%0d", i), exp1[i], 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1 tail in_ready", 32'(a_in_ready), 32'd0);
    checkOutput("t1 tail busy",     32'(a_busy),     32'd1);
    for (int i = 4; i < 6; i++) begin
      tick();
      checkSymA($sformatf("t1 sym%0d", i), exp1[i], (i == 5));
    end
    checkOutput("t1 end in_ready", 32'(a_in_ready), 32'd1);
    tick();
    checkOutput("t1 idle valid", 32'(a_out_valid), 32'd0);
    checkOutput("t1 idle busy",  32'(a_busy),      32'd0);

    // Same frame with three cycles of backpressure after the first symbol
    applyStimulus(1'b1, bits1[0], 1'b0, 1'b1);
    tick();
    checkSymA("t2 sym0", exp1[0], 1'b0);
    applyStimulus(1'b1, bits1[1], 1'b0, 1'b0);
    checkOutput("t2 stall in_ready", 32'(a_in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkSymA($sformatf("t2 hold%0d", c), exp1[0], 1'b0);
      checkOutput($sformatf("t2 hold%0d in_ready", c), 32'(a_in_ready), 32'd0);
    end
    applyStimulus(1'b1, bits1[1], 1'b0, 1'b1);
    checkOutput("t2 release in_ready", 32'(a_in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, bits1[i], (i == 3), 1'b1);
      tick();
      checkSymA($sformatf("t2 sym%0d", i), exp1[i], 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 4; i < 6; i++) begin
      tick();
      checkSymA($sformatf("t2 sym%0d", i), exp1[i], (i == 5));
    end
    tick();
    checkOutput("t2 idle valid", 32'(a_out_valid), 32'd0);

    // Stream mode: 1, 1(last), then 1 restarts from state zero
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkSymB("t3 sym0", 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkSymB("t3 sym1", 2'b01, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkSymB("t3 sym2", 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the first tail cycle
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkSymA("t4 sym0", 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checkOutput("t4 valid",    32'(a_out_valid), 32'd0);
    checkOutput("t4 busy",     32'(a_busy),      32'd0);
    checkOutput("t4 in_ready", 32'(a_in_ready),  32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkSymA("t4 next", 2'b11, 1'b0);

    // Back-to-back one-bit frames with no idle cycle
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkSymA("t5 sym0", 2'b11, 1'b0);
    checkOutput("t5 sym0 in_ready", 32'(a_in_ready), 32'd0);
    tick();
    checkSymA("t5 sym1", 2'b10, 1'b0);
    checkOutput("t5 sym1 in_ready", 32'(a_in_ready), 32'd0);
    tick();
    checkSymA("t5 sym2", 2'b11, 1'b1);
    checkOutput("t5 sym2 in_ready", 32'(a_in_ready), 32'd1);
    tick();
    checkSymA("t5 sym3", 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkSymA("t5 sym4", 2'b10, 1'b0);
    tick();
    checkSymA("t5 sym5", 2'b11, 1'b1);
    tick();
    checkOutput("t5 idle valid", 32'(a_out_valid), 32'd0);

`ifdef CONV_ENC_PUNCT_EN
    // Puncturing pattern 11/10 alternates across data and tail symbols
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, bits1[i], (i == 3), 1'b1);
      tick();
      checkSymA($sformatf("p sym%0d", i), exp1[i], 1'b0);
      checkOutput($sformatf("p mask%0d", i), 32'(a_out_mask), 32'(mask1[i]));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 4; i < 6; i++) begin
      tick();
      checkSymA($sformatf("p sym%0d", i), exp1[i], (i == 5));
      checkOutput($sformatf("p mask%0d", i), 32'(a_out_mask), 32'(mask1[i]));
    end
`endif

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised feed-forward convolutional encoder with rate 1/N and constraint length K. It sits between the bit source and the modulator/interleaver. It takes one information bit per handshake and emits one N-bit coded symbol per handshake. The output is registered and uses a valid/ready interface. Frames are optionally terminated with K-1 zero tail bits, which returns the encoder to state zero.

Parameters:
K, 3, constraint length; 2..9; shift register holds K-1 bits.
N, 2, number of generator polynomials, equal to the symbol width; 2..8.
G, {3'b111,3'b101}, N*K-bit packed generator set.
- Slice j (j=0 in the MSB slice) drives out_sym[N-1-j].
- Within each slice, bit K-1 taps the current input and bit 0 taps the oldest register bit.
TERM_MODE, 1, frame termination mode.
- 0 = stream: out_last mirrors in_last; the register clears after the last bit.
- 1 = zero-tail: K-1 zero bits are appended after in_last.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
in_valid  in  1  in_bit/in_last valid
in_ready  out  1  encoder accepts input this cycle
in_bit  in  1  information bit
in_last  in  1  last information bit of the frame
out_valid  out  1  out_sym valid
out_ready  in  1  downstream accepts the symbol
out_sym  out  N  coded symbol; bit j = XOR over (G slice & {in, sreg})
out_last  out  1  final symbol of the frame
busy  out  1  high in S_TAIL or while out_valid=1

Behaviour:
- Reset (RST high at a CLK edge): sreg=0, FSM=S_DATA, out_valid=0, out_sym=0, out_last=0, tail counter=0, busy=0. Reset wins over any handshake in the same cycle. A reset mid-frame or mid-tail discards the pending symbol and all tail state.
- slot_free = !out_valid || out_ready.
- Output register is loaded on every emit. out_valid is cleared when out_ready=1 and nothing is emitted that cycle.
- Latency: one cycle from input accept to out_valid. Throughput: one symbol per cycle with out_ready held at 1.
- While out_valid=1 && out_ready=0, out_sym and out_last are held stable.
- in_ready = (FSM==S_DATA) && slot_free. It is purely combinational from state and out_ready, never from in_valid.
- Shift rule on accept or tail step: sreg <= {sreg[K-3:0], b}, where b is the input bit (0 during tail). The newest bit sits at sreg[0]; the oldest at sreg[K-2].
- FSM state S_DATA:
  - Accept when in_valid && in_ready; emit the symbol computed from in_bit.
  - If in_last && TERM_MODE==1: out_last=0, go to S_TAIL, tail counter=0.
  - If in_last && TERM_MODE==0: out_last=1 and sreg<=0, so the next frame starts from state zero.
- FSM state S_TAIL:
  - On each cycle with slot_free, emit the symbol for b=0 and increment the counter.
  - On step K-2 (the final tail step): out_last=1, sreg becomes 0, return to S_DATA.
  - Input is blocked throughout S_TAIL.
- A one-bit frame (in_last on the first bit) is legal and yields 1+(K-1) symbols in mode 1.
- Back-to-back frames: the first bit of the next frame may be accepted in the same cycle that the final tail symbol is taken by the downstream (out_ready=1).
- in_valid low: no state change. A bubble never alters sreg.

Optional Feature:
Macro CONV_ENC_PUNCT_EN. When defined:
- Added parameters: PUNCT_P (default 2) and PUNCT_PAT (N*PUNCT_P bits, default 4'b1110; phase 0 in the MSB slice).
- Added output port: out_mask [N-1:0], giving the mask of the current phase.
- A phase counter advances on each encoded symbol (including tail symbols), wraps at PUNCT_P-1, and resets to 0 on RST and after every out_last symbol.
- Symbols whose mask is all zero are not emitted: sreg still shifts, but out_valid is not raised.
When not defined:
- out_mask is absent and every bit of out_sym is valid.
- The logic is identical to the unpunctured encoder.

Decomposition:
- Package conv_enc_pkg holds:
  - FSM enum {S_DATA, S_TAIL}
  - TERM_STREAM=0 and TERM_ZERO=1 constants
  - default generator constants G_K3_75 = {3'b111,3'b101} and G_K7_171_133
- Sub-module conv_enc_parity: combinational XOR-reduction of one K-bit generator slice against {b, sreg}. It is instantiated N times via generate.

Test Plan:
- Default params, mode 1, frame 1,0,1,1 (in_last on the 4th bit), out_ready=1 -> out_sym 11,10,00,01,01,11; out_last only on the 6th symbol; sreg=0 afterwards.
- Same frame with out_ready held 0 for 3 cycles after the first symbol -> out_sym stays 11 and in_ready=0 throughout; the sequence then resumes unchanged.
- Mode 0, stream 1,1 (last), then 1 -> 11,01 with out_last on the 2nd symbol; third symbol is 11 (state restarted at zero).
- Reset pulsed during the first tail cycle -> out_valid=0 next cycle, busy=0, in_ready=1; the following frame with bit 1 gives 11.
- Back-to-back one-bit frames 1(last),1(last), mode 1 -> 11,10,11,11,10,11 with no idle cycle between the two frames.
- With CONV_ENC_PUNCT_EN and PUNCT_PAT=4'b1110, frame 1,0,1,1 -> out_mask alternates 11,10,11,10,11,10 over six symbols; no symbols are dropped.
